// File: rtl/seq_multiplier_n.sv
// Shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or signed per operation.
// Signed operands are reduced to magnitudes on accept; the sign is reapplied once in FIX.
module seq_multiplier_n #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 done_q, done_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;

   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   full;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mplier_d  = mplier_q;
      mcand_d   = mcand_q;
      count_d   = count_q;
      neg_d     = neg_q;
      product_d = product_q;
      done_d    = 1'b0;

      // The adder carry lands in the accumulator MSB through the fused shift.
      sum  = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      full = {acc_q, mplier_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = (signed_mode && a[WIDTH-1]) ? -a : a;
               mplier_d = (signed_mode && b[WIDTH-1]) ? -b : b;
               neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d    = '0;
               count_d  = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (count_q == CW'(WIDTH)) begin
               state_d = FIX;
            end else begin
               acc_d    = sum[WIDTH:1];
               mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
               count_d  = count_q + 1'b1;
            end
         end
         FIX: begin
            product_d = neg_q ? -full : full;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mplier_q  <= '0;
         mcand_q   <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mplier_q  <= mplier_d;
         mcand_q   <= mcand_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         product_q <= product_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   assign ready   = ready_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Bench for seq_multiplier_n at WIDTH=8 and WIDTH=4: directed cases, handshake corners, random ops.
// Expected products come from plain integer arithmetic on the operand values.
module tb_seq_multiplier_n;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start8, sm8, ready8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] prod8;
   logic        start4, sm4, ready4, busy4, done4;
   logic [3:0]  a4, b4;
   logic [7:0]  prod4;

   int errors = 0;
   int checks = 0;

   seq_multiplier_n #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
      .ready(ready8), .busy(busy8), .done(done8), .product(prod8)
   );

   seq_multiplier_n #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
      .ready(ready4), .busy(busy4), .done(done4), .product(prod4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Interpret operands as w-bit values, multiply as integers, keep 2w bits.
   function automatic logic [31:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic sm, input int w);
      longint m, sx, sy, p;
      m  = longint'(1) << w;
      sx = longint'(x) & (m - 1);
      sy = longint'(y) & (m - 1);
      if (sm && sx >= m / 2) sx = sx - m;
      if (sm && sy >= m / 2) sy = sy - m;
      p = sx * sy;
      return 32'(p & (m * m - 1));
   endfunction

   task automatic op(input int w, input logic [7:0] ta, input logic [7:0] tb,
                     input logic sm, input string tag);
      int cyc, busy_low;
      logic [31:0] exp;
      logic d;
      exp = model(ta, tb, sm, w);
      if (w == 8) begin
         check({tag, "_ready"}, 32'(ready8), 32'd1);
         start8 = 1'b1; a8 = ta; b8 = tb; sm8 = sm;
      end else begin
         check({tag, "_ready"}, 32'(ready4), 32'd1);
         start4 = 1'b1; a4 = ta[3:0]; b4 = tb[3:0]; sm4 = sm;
      end
      @(posedge clk); #1;
      start8 = 1'b0; start4 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      cyc = 0; busy_low = 0;
      d = (w == 8) ? done8 : done4;
      while (!d && cyc < 40) begin
         if (((w == 8) ? busy8 : busy4) !== 1'b1) busy_low++;
         @(posedge clk); #1;
         cyc++;
         d = (w == 8) ? done8 : done4;
      end
      check({tag, "_lat"}, 32'(cyc), 32'(w + 2));
      check({tag, "_prod"}, (w == 8) ? 32'(prod8) : 32'(prod4), exp);
      check({tag, "_busy"}, 32'(busy_low), 32'd0);
   endtask

   initial begin
      int ndone, first;
      rst = 1'b1;
      start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
      #12;
      check("rst_prod", 32'(prod8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_ready", 32'(ready8), 32'd1);
      check("rst_ready4", 32'(ready4), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      op(8, 8'hFF, 8'hFF, 1'b0, "u_ffff");
      op(8, 8'h80, 8'h80, 1'b1, "s_8080");
      op(8, 8'h7F, 8'h80, 1'b1, "s_7f80");
      op(8, 8'hFD, 8'h05, 1'b1, "s_fd05");
      op(8, 8'hFF, 8'h02, 1'b0, "u_ff02");
      op(8, 8'hFF, 8'h02, 1'b1, "s_ff02");
      // Issued in the done cycle of the previous op: back-to-back accept.
      op(8, 8'h03, 8'h04, 1'b0, "b2b");
      @(posedge clk); #1;
      check("done_drop", 32'(done8), 32'd0);
      check("prod_hold", 32'(prod8), 32'h000C);

      // A second start while busy must be ignored.
      start8 = 1'b1; a8 = 8'd5; b8 = 8'd6; sm8 = 1'b0;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      start8 = 1'b1; a8 = 8'd9; b8 = 8'd9; sm8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      ndone = 0; first = -1;
      for (int c = 5; c <= 30; c++) begin
         @(posedge clk); #1;
         if (done8) begin
            ndone++;
            if (first < 0) first = c;
         end
      end
      check("ign_ndone", 32'(ndone), 32'd1);
      check("ign_lat", 32'(first), 32'd10);
      check("ign_prod", 32'(prod8), 32'd30);

      // Asynchronous reset between edges in the middle of RUN.
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b0;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_prod", 32'(prod8), 32'd0);
      check("arst_busy", 32'(busy8), 32'd0);
      check("arst_done", 32'(done8), 32'd0);
      check("arst_ready", 32'(ready8), 32'd1);
      #2 rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (done8) ndone++;
      end
      check("arst_nodone", 32'(ndone), 32'd0);
      op(8, 8'h12, 8'h34, 1'b0, "post_rst");

      op(4, 8'h0F, 8'h0F, 1'b0, "w4_ff");
      op(4, 8'h08, 8'h08, 1'b1, "w4_s88");
      op(4, 8'h0D, 8'h03, 1'b1, "w4_sd3");
      for (int i = 0; i < 10; i++)
         op(4, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "w4_rnd");
      for (int i = 0; i < 30; i++)
         op(8, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "w8_rnd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
